// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key-path types and 50 MHz default timing
package keypad_pkg;
  typedef enum logic [2:0] {IDLE, DB_PRESS, PRESSED, REPEAT, DB_REL} state_t;
  localparam int KEY_W = 4;
  localparam int DEF_DEBOUNCE = 500000;
  localparam int DEF_REPEAT_DELAY = 25000000;
  localparam int DEF_REPEAT_PERIOD = 5000000;
  localparam int DEF_CNT_W = 25;
endpackage

// File: rtl/key_event_filter_stable_counter.sv
// stable_counter: clear/increment counter with terminal-count compare, saturating at all-ones
module stable_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] q,
  output logic         tc
);
  always_ff @(posedge clk)
    if (!rst_n || clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
  assign tc = q == last;
endmodule

// File: rtl/key_event_filter.sv
// key_event_filter: debounces scanner key codes into press/repeat/release events
module key_event_filter
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter bit REPEAT_EN = 1'b1,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] raw_code,
  input  logic             raw_pressed,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held,
  output logic             key_release,
  output logic [7:0]       key_count
);
  state_t state;
  logic [KEY_W-1:0] cand;
  logic [CNT_W-1:0] cnt, rpt;
  logic cnt_tc, rpt_tc, match, held_st;
  assign match = raw_pressed && raw_code == (state == DB_PRESS ? cand : key_code);
  assign held_st = state == PRESSED || state == REPEAT;
  stable_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n),
    .clr((state == IDLE && raw_pressed) || (held_st && !match)),
    .inc(!cnt_tc && ((state == DB_PRESS && match) || (state == DB_REL && !match))),
    .last(CNT_W'(DEBOUNCE_CYCLES - 1)),
    .q(cnt), .tc(cnt_tc)
  );
  // repeat timer restarts on acceptance, on every repeat pulse and on a bounce back into PRESSED
  stable_counter #(.W(CNT_W)) u_rpt (
    .clk(clk), .rst_n(rst_n),
    .clr(match && ((state == DB_PRESS && cnt_tc) || (state == PRESSED && REPEAT_EN && rpt_tc) ||
                   (state == REPEAT && rpt_tc) || state == DB_REL)),
    .inc(held_st && match),
    .last(state == REPEAT ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1)),
    .q(rpt), .tc(rpt_tc)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cand <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
      key_release <= 1'b0;
      key_count <= '0;
    end else begin
      key_valid <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: if (raw_pressed) begin
          cand <= raw_code;
          state <= DB_PRESS;
        end
        DB_PRESS: if (!match) state <= IDLE;
        else if (cnt_tc) begin
          state <= PRESSED;
          key_code <= cand;
          key_held <= 1'b1;
          key_valid <= 1'b1;
          key_count <= key_count + 8'd1;
        end
        PRESSED: if (!match) state <= DB_REL;
        else if (REPEAT_EN && rpt_tc) begin
          state <= REPEAT;
          key_valid <= 1'b1;
        end
        REPEAT: if (!match) state <= DB_REL;
        else if (rpt_tc) key_valid <= 1'b1;
        DB_REL: if (match) state <= PRESSED;
        else if (cnt_tc) begin
          state <= IDLE;
          key_held <= 1'b0;
          key_release <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_event_filter.sv
// tb_key_event_filter: directed checks of debounce, repeat, release and reset behaviour
module tb_key_event_filter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] raw_code = 4'h0;
  logic raw_pressed = 1'b0;
  logic [3:0] key_code, key_code0;
  logic key_valid, key_held, key_release, key_valid0, key_held0, key_release0;
  logic [7:0] key_count, key_count0;
  int checks = 0, errors = 0;
  int vcnt = 0, rcnt = 0, vcnt0 = 0, bad3 = 0, overlap = 0;
  always #5 clk = ~clk;
  key_event_filter #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .raw_code(raw_code), .raw_pressed(raw_pressed),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .key_release(key_release), .key_count(key_count)
  );
  key_event_filter #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .raw_code(raw_code), .raw_pressed(raw_pressed),
    .key_code(key_code0), .key_valid(key_valid0), .key_held(key_held0),
    .key_release(key_release0), .key_count(key_count0)
  );
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      vcnt += int'(key_valid);
      rcnt += int'(key_release);
      vcnt0 += int'(key_valid0);
      if (key_valid && key_code == 4'h3) bad3++;
      if (key_valid && key_release) overlap++;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    raw_pressed = 1'b0;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    vcnt = 0; rcnt = 0; vcnt0 = 0;
  endtask
  initial begin
    raw_pressed = 1'b1; raw_code = 4'h9;
    tick(3);
    chk("rst_code", key_code, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_release", key_release, 0);
    chk("rst_count", key_count, 0);
    rst_n = 1'b1;
    tick(4);
    chk("post_rst_early", key_valid, 0);
    tick(1);
    chk("post_rst_valid", key_valid, 1);
    chk("post_rst_code", key_code, 4'h9);
    do_reset();
    raw_pressed = 1'b1; raw_code = 4'h5;
    tick(5);
    chk("clean_valid", key_valid, 1);
    chk("clean_code", key_code, 4'h5);
    chk("clean_count", key_count, 1);
    tick(1);
    chk("clean_valid_drop", key_valid, 0);
    chk("clean_held", key_held, 1);
    raw_pressed = 1'b0;
    tick(4);
    chk("clean_rel_early", key_release, 0);
    tick(1);
    chk("clean_release", key_release, 1);
    chk("clean_held_fall", key_held, 0);
    chk("clean_code_kept", key_code, 4'h5);
    tick(1);
    chk("clean_rel_drop", key_release, 0);
    chk("clean_pulses", vcnt, 1);
    do_reset();
    raw_code = 4'h6;
    raw_pressed = 1'b1; tick(2);
    raw_pressed = 1'b0; tick(1);
    raw_pressed = 1'b1; tick(2);
    raw_pressed = 1'b0; tick(1);
    chk("bounce_none", vcnt, 0);
    raw_pressed = 1'b1; tick(4);
    chk("bounce_early", key_valid, 0);
    tick(1);
    chk("bounce_valid", key_valid, 1);
    chk("bounce_count", key_count, 1);
    chk("bounce_pulses", vcnt, 1);
    do_reset();
    raw_pressed = 1'b1; raw_code = 4'h3; tick(2);
    raw_code = 4'h7; tick(5);
    chk("chg_early", key_valid, 0);
    tick(1);
    chk("chg_valid", key_valid, 1);
    chk("chg_code", key_code, 4'h7);
    chk("chg_no3", bad3, 0);
    do_reset();
    raw_pressed = 1'b1; raw_code = 4'h2; tick(5);
    chk("rpt_accept", key_valid, 1);
    tick(9);
    chk("rpt_before_first", key_valid, 0);
    tick(1);
    chk("rpt_first", key_valid, 1);
    tick(25);
    chk("rpt_pulses35", vcnt, 7);
    tick(4);
    chk("rpt_pulses39", vcnt, 7);
    chk("rpt_count", key_count, 1);
    chk("norpt_pulses", vcnt0, 1);
    chk("norpt_held", key_held0, 1);
    raw_pressed = 1'b0; tick(2);
    raw_pressed = 1'b1; tick(1);
    chk("glitch_held", key_held, 1);
    chk("glitch_no_rel", rcnt, 0);
    tick(9);
    chk("glitch_no_extra", vcnt, 7);
    tick(1);
    chk("glitch_repeat", key_valid, 1);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_code", key_code, 0);
    chk("mid_rst_held", key_held, 0);
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_count", key_count, 0);
    chk("mid_rst_release", key_release, 0);
    rst_n = 1'b1;
    chk("no_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_event_filter.md
Name: key_event_filter

Overview:
- Sits between the keypad scanner and the consumers of key data: the 7-segment digit path and the Pacman direction logic.
- Takes the scanner's raw 4-bit key code and its pressed flag, both synchronous to clk.
- Debounces press and release, and emits one-cycle key events with optional auto-repeat.
- Holds the last accepted code so the display shows a stable digit.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a press or a release (10 ms at 50 MHz); minimum 1.
- REPEAT_EN, 1: 1 enables auto-repeat of key_valid while a key is held.
- REPEAT_DELAY, 25000000: cycles from acceptance to the first repeat pulse; minimum 1.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat pulses; minimum 1.
- CNT_W, 25: counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) - 1.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst_n, input, 1: synchronous active-low reset.
- raw_code, input, 4: key code from the scanner; meaningful only while raw_pressed = 1.
- raw_pressed, input, 1: scanner reports a key down.
- key_code, output, 4: last accepted code; held until the next acceptance; drives the display decoder.
- key_valid, output, 1: one-cycle pulse on acceptance and on each repeat.
- key_held, output, 1: level, high from acceptance until the release is accepted.
- key_release, output, 1: one-cycle pulse when the release is accepted.
- key_count, output, 8: accepted-press counter; excludes repeats; wraps 255 -> 0.

Behaviour:
- Reset, sampled at a rising edge with rst_n = 0: state = IDLE; key_code = 0; key_valid, key_held, key_release = 0; key_count = 0; all counters = 0.
- Reset overrides every other condition, including mid-debounce and mid-repeat.
- Match condition: raw_pressed = 1 and raw_code = the reference code. The reference code is cand in DB_PRESS and key_code otherwise.
- State IDLE:
  - On raw_pressed = 1: cand <= raw_code, cnt <= 0, go to DB_PRESS.
- State DB_PRESS:
  - On mismatch: go to IDLE, no output change.
  - Else, if cnt = DEBOUNCE_CYCLES-1: go to PRESSED; key_code <= cand; key_held <= 1; pulse key_valid; key_count++; rpt <= 0.
  - Else: cnt++.
- Press latency: key_valid is high in the cycle after the (DEBOUNCE_CYCLES+1)-th consecutive edge that samples the same pressed code.
- State PRESSED:
  - On mismatch: go to DB_REL, cnt <= 0.
  - Else, if REPEAT_EN and rpt = REPEAT_DELAY-1: go to REPEAT, pulse key_valid, rpt <= 0.
  - Else: rpt++. When REPEAT_EN = 0, rpt saturates.
- State REPEAT:
  - On mismatch: go to DB_REL, cnt <= 0.
  - Else, if rpt = REPEAT_PERIOD-1: pulse key_valid, rpt <= 0.
  - Else: rpt++.
- State DB_REL:
  - On match: go to PRESSED with rpt <= 0, no pulse. The repeat timer restarts from the delay.
  - Else, if cnt = DEBOUNCE_CYCLES-1: go to IDLE; key_held <= 0; pulse key_release.
  - Else: cnt++.
- Key change while held: a different code counts as a mismatch. The old key must pass release debounce first. The new code then debounces from IDLE on the next edge.
- key_valid and key_release are never high together, and never high for two consecutive cycles. The one exception is REPEAT_PERIOD = 1, where key_valid stays high continuously.
- key_code does not change on release; the display keeps the last digit.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package (keypad_pkg):
  - State enum: IDLE, DB_PRESS, PRESSED, REPEAT, DB_REL.
  - KEY_W = 4.
  - Default timing constants, defined for 50 MHz.
- One sub-module is natural: stable_counter. It is a clear/increment/terminal-count counter parameterised on width. It is instantiated twice: once for debounce (cnt) and once for repeat (rpt).

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, CNT_W=8 unless stated.
- Reset: hold rst_n=0 for 3 edges with raw_pressed=1, raw_code=0x9 -> all outputs 0. After release of reset, key_valid rises only after 5 further matching edges.
- Clean press: raw_code=0x5 held 5 edges, then release held 5 edges -> key_valid pulse for 1 cycle, key_code=0x5, key_count=1. Then key_release pulse for 1 cycle; key_held falls; key_code stays 0x5.
- Bounce: pattern pressed 2, off 1, pressed 2, off 1, then pressed 5 -> exactly one key_valid, after the final 5-edge run; key_count=1.
- Code change during debounce: 0x3 for 2 edges, then 0x7 held -> debounce restarts; key_code=0x7; no pulse ever carries 0x3.
- Auto-repeat: 0x2 held 40 edges after acceptance -> key_valid at acceptance, +10, +15, +20, +25, +30, +35 (7 pulses); key_count=1.
  - With REPEAT_EN=0 -> 1 pulse only.
- Release glitch: during REPEAT, raw_pressed=0 for 2 edges, then re-press -> no key_release, key_held stays 1, no extra key_valid; next repeat pulse comes 10 edges after return.
  - rst_n=0 mid-REPEAT -> all outputs 0 on the next edge.
